// File: rtl/bram_group_if.sv
// Port bundle for bram_group_arb: per-bank write ports plus per-client read request/return.
interface bram_group_if #(
    parameter int BANK_NUM        = 4,
    parameter int BANK_UNIT_NUM   = 8,
    parameter int BANK_UNIT_WIDTH = 8,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int CLIENT_NUM      = 3
);
    localparam int DW  = BANK_UNIT_NUM * BANK_UNIT_WIDTH;
    localparam int BSW = $clog2(BANK_NUM);

    logic [BANK_NUM-1:0]                 wr_en_i;
    logic [BANK_NUM*BANK_ADDR_WIDTH-1:0] wr_addr_i;
    logic [BANK_NUM*DW-1:0]              wr_data_i;
    logic [BANK_NUM*BANK_UNIT_NUM-1:0]   wr_unit_mask_i;
    logic [CLIENT_NUM-1:0]               rd_req_i;
    logic [CLIENT_NUM*BSW-1:0]           rd_bank_i;
    logic [CLIENT_NUM*BANK_ADDR_WIDTH-1:0] rd_addr_i;
    logic [CLIENT_NUM-1:0]               rd_gnt_o;
    logic [CLIENT_NUM-1:0]               rd_valid_o;
    logic [CLIENT_NUM*DW-1:0]            rd_data_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, wr_unit_mask_i, rd_req_i, rd_bank_i, rd_addr_i,
        input  rd_gnt_o, rd_valid_o, rd_data_o
    );
    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, wr_unit_mask_i, rd_req_i, rd_bank_i, rd_addr_i,
        output rd_gnt_o, rd_valid_o, rd_data_o
    );
endinterface

// File: rtl/bram_group_arb.sv
// Banked BRAM group with per-bank round-robin read arbitration and a fixed 2-cycle read return.
// Optional macro BRAM_GROUP_WR_FWD_EN forwards same-cycle write data into a colliding read.
module bram_group_arb #(
    parameter int BANK_NUM        = 4,
    parameter int BANK_UNIT_NUM   = 8,
    parameter int BANK_UNIT_WIDTH = 8,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int CLIENT_NUM      = 3
) (
    input logic         clk,
    input logic         rst_n,
    bram_group_if.slave bus
);
    localparam int DW    = BANK_UNIT_NUM * BANK_UNIT_WIDTH;
    localparam int DEPTH = 2 ** BANK_ADDR_WIDTH;
    localparam int BSW   = $clog2(BANK_NUM);
    localparam int CW    = (CLIENT_NUM > 1) ? $clog2(CLIENT_NUM) : 1;

    logic [BANK_NUM-1:0][CW-1:0]              ptr_q, ptr_d;
    logic [BANK_NUM-1:0]                      s1_vld_q, s1_vld_d;
    logic [BANK_NUM-1:0][CW-1:0]              s1_cli_q, s1_cli_d;
    logic [BANK_NUM-1:0][BANK_ADDR_WIDTH-1:0] gnt_addr;
    logic [DW-1:0]                            bank_rdata [BANK_NUM];
    logic [CLIENT_NUM-1:0]                    gnt;
    logic [CLIENT_NUM-1:0]                    rd_valid_q, rd_valid_d;
    logic [CLIENT_NUM-1:0][DW-1:0]            rd_data_q, rd_data_d;

    // Per-bank arbitration: search upward from ptr, first matching requester wins.
    always_comb begin
        logic          found;
        logic [CW-1:0] ci;
        int            idx;
        gnt      = '0;
        ptr_d    = ptr_q;
        s1_vld_d = '0;
        s1_cli_d = s1_cli_q;
        gnt_addr = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            found = 1'b0;
            for (int off = 0; off < CLIENT_NUM; off++) begin
                idx = (int'(ptr_q[b]) + off) % CLIENT_NUM;
                ci  = CW'(idx);
                if (!found && bus.rd_req_i[ci] &&
                    bus.rd_bank_i[idx*BSW +: BSW] == BSW'(b)) begin
                    found       = 1'b1;
                    gnt[ci]     = 1'b1;
                    s1_vld_d[b] = 1'b1;
                    s1_cli_d[b] = ci;
                    gnt_addr[b] = bus.rd_addr_i[idx*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
                    ptr_d[b]    = CW'((idx + 1) % CLIENT_NUM);
                end
            end
        end
        if (!rst_n) begin
            gnt      = '0;
            s1_vld_d = '0;
        end
    end

    for (genvar gb = 0; gb < BANK_NUM; gb++) begin : g_bank
        logic [DW-1:0]              mem [DEPTH];
        logic [DW-1:0]              rdata_q;
        logic [BANK_ADDR_WIDTH-1:0] waddr;
        logic [BANK_UNIT_NUM-1:0]   wmask;
        logic [DW-1:0]              wdata;

        assign waddr = bus.wr_addr_i[gb*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
        assign wmask = bus.wr_unit_mask_i[gb*BANK_UNIT_NUM +: BANK_UNIT_NUM];
        assign wdata = bus.wr_data_i[gb*DW +: DW];

        // Read samples the array on the same edge as the write, so a collision sees old data.
        always_ff @(posedge clk) begin
            if (s1_vld_d[gb])
                rdata_q <= mem[gnt_addr[gb]];
            if (bus.wr_en_i[gb])
                for (int u = 0; u < BANK_UNIT_NUM; u++)
                    if (wmask[u])
                        mem[waddr][u*BANK_UNIT_WIDTH +: BANK_UNIT_WIDTH] <=
                            wdata[u*BANK_UNIT_WIDTH +: BANK_UNIT_WIDTH];
        end

`ifdef BRAM_GROUP_WR_FWD_EN
        logic [DW-1:0] fwd_bits_q, fwd_data_q;
        always_ff @(posedge clk) begin
            if (s1_vld_d[gb]) begin
                fwd_data_q <= wdata;
                for (int u = 0; u < BANK_UNIT_NUM; u++)
                    fwd_bits_q[u*BANK_UNIT_WIDTH +: BANK_UNIT_WIDTH] <=
                        {BANK_UNIT_WIDTH{bus.wr_en_i[gb] && wmask[u] && waddr == gnt_addr[gb]}};
            end
        end
        assign bank_rdata[gb] = (rdata_q & ~fwd_bits_q) | (fwd_data_q & fwd_bits_q);
`else
        assign bank_rdata[gb] = rdata_q;
`endif
    end

    // Return stage: each bank's result is routed to the client it served.
    always_comb begin
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (s1_vld_q[b]) begin
                rd_valid_d[s1_cli_q[b]] = 1'b1;
                rd_data_d[s1_cli_q[b]]  = bank_rdata[b];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            s1_vld_q   <= '0;
            s1_cli_q   <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_vld_q   <= s1_vld_d;
            s1_cli_q   <= s1_cli_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_gnt_o   = gnt;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
endmodule

// File: tb/tb_bram_group_arb.sv
// Directed bench for bram_group_arb: arbiter/memory model with per-client expected-return queues.
module tb_bram_group_arb;
    localparam int NB = 4, NU = 8, AW = 12, NC = 3, DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bram_group_if #(.BANK_NUM(NB), .BANK_UNIT_NUM(NU), .BANK_UNIT_WIDTH(8),
                    .BANK_ADDR_WIDTH(AW), .CLIENT_NUM(NC)) bus ();

    bram_group_arb #(.BANK_NUM(NB), .BANK_UNIT_NUM(NU), .BANK_UNIT_WIDTH(8),
                     .BANK_ADDR_WIDTH(AW), .CLIENT_NUM(NC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { logic [DW-1:0] d; int due; } exp_t;
    exp_t          sb [NC][$];
    logic [DW-1:0] mdl [int];
    logic [DW-1:0] last [NC];
    int            mptr [NB];
    int            cyc = 0, errors = 0, checks = 0;

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int key(int b, int a);
        return b * 4096 + a;
    endfunction

    task automatic clear_in();
        bus.wr_en_i = '0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.wr_unit_mask_i = '0;
        bus.rd_req_i = '0; bus.rd_bank_i = '0; bus.rd_addr_i = '0;
    endtask

    task automatic set_wr(int b, int a, logic [DW-1:0] d, logic [NU-1:0] m);
        bus.wr_en_i[b] = 1'b1;
        bus.wr_addr_i[b*AW +: AW] = AW'(a);
        bus.wr_data_i[b*DW +: DW] = d;
        bus.wr_unit_mask_i[b*NU +: NU] = m;
    endtask

    task automatic set_rd(int c, int b, int a);
        bus.rd_req_i[c] = 1'b1;
        bus.rd_bank_i[c*2 +: 2] = 2'(b);
        bus.rd_addr_i[c*AW +: AW] = AW'(a);
    endtask

    task automatic apply_wr();
        logic [DW-1:0] t;
        int k;
        for (int b = 0; b < NB; b++) begin
            if (bus.wr_en_i[b]) begin
                k = key(b, int'(bus.wr_addr_i[b*AW +: AW]));
                t = mdl.exists(k) ? mdl[k] : '0;
                for (int u = 0; u < NU; u++)
                    if (bus.wr_unit_mask_i[b*NU+u])
                        t[u*8 +: 8] = bus.wr_data_i[b*DW + u*8 +: 8];
                mdl[k] = t;
            end
        end
    endtask

    task automatic check_out();
        exp_t e;
        for (int c = 0; c < NC; c++) begin
            if (sb[c].size() > 0 && sb[c][0].due == cyc) begin
                e = sb[c].pop_front();
                chk($sformatf("valid%0d@%0d", c, cyc), 64'(bus.rd_valid_o[c]), 64'd1);
                chk($sformatf("data%0d@%0d", c, cyc), bus.rd_data_o[c*DW +: DW], e.d);
                last[c] = e.d;
            end else begin
                chk($sformatf("idle%0d@%0d", c, cyc), 64'(bus.rd_valid_o[c]), 64'd0);
                chk($sformatf("hold%0d@%0d", c, cyc), bus.rd_data_o[c*DW +: DW], last[c]);
            end
        end
    endtask

    // One clock: predict grants, queue expected returns, advance, check returns.
    task automatic go();
        logic [NC-1:0] eg;
        logic [NB-1:0] done;
        int c;
        eg = '0;
        done = '0;
        #1;
`ifdef BRAM_GROUP_WR_FWD_EN
        apply_wr();
`endif
        for (int b = 0; b < NB; b++) begin
            for (int o = 0; o < NC; o++) begin
                c = (mptr[b] + o) % NC;
                if (!done[b] && bus.rd_req_i[c] && int'(bus.rd_bank_i[c*2 +: 2]) == b) begin
                    done[b] = 1'b1;
                    eg[c] = 1'b1;
                    mptr[b] = (c + 1) % NC;
                    sb[c].push_back('{d: mdl[key(b, int'(bus.rd_addr_i[c*AW +: AW]))], due: cyc + 2});
                end
            end
        end
        chk($sformatf("gnt@%0d", cyc), 64'(bus.rd_gnt_o), 64'(eg));
`ifndef BRAM_GROUP_WR_FWD_EN
        apply_wr();
`endif
        @(posedge clk);
        cyc++;
        #1;
        check_out();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int c = 0; c < NC; c++) begin
            sb[c].delete();
            last[c] = '0;
        end
        for (int b = 0; b < NB; b++) mptr[b] = 0;
        #1;
        chk("rst_gnt", 64'(bus.rd_gnt_o), 64'd0);
        chk("rst_valid", 64'(bus.rd_valid_o), 64'd0);
        for (int c = 0; c < NC; c++)
            chk($sformatf("rst_data%0d", c), bus.rd_data_o[c*DW +: DW], 64'd0);
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int rb;
        clear_in();
        #1;
        set_rd(0, 0, 0);
        do_reset();
        clear_in();

        // full write then read back
        set_wr(1, 'h10, 64'h0807060504030201, 8'hFF); go(); clear_in();
        set_rd(0, 1, 'h10); go(); clear_in(); go(); go();

        // partial unit-mask write
        set_wr(1, 'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F); go(); clear_in();
        set_rd(0, 1, 'h10); go(); clear_in(); go(); go();

        // round robin on bank2 from reset; RAM contents survive the reset
        for (int c = 0; c < NC; c++) begin
            set_wr(2, c + 1, {8{8'(8'h30 + c)}}, 8'hFF); go(); clear_in();
        end
        for (int c = 0; c < NC; c++) set_rd(c, 2, c + 1);
        do_reset();
        repeat (6) go();
        clear_in(); go(); go(); go();

        // three clients on three different banks in one cycle
        set_wr(0, 'h20, 64'hA0A0A0A0A0A0A0A0, 8'hFF);
        set_wr(1, 'h20, 64'hB1B1B1B1B1B1B1B1, 8'hFF);
        set_wr(3, 'h20, 64'hD3D3D3D3D3D3D3D3, 8'hFF);
        go(); clear_in();
        set_rd(0, 0, 'h20); set_rd(1, 1, 'h20); set_rd(2, 3, 'h20);
        go(); clear_in(); go(); go();

        // same-cycle write/read collision, full then partial mask
        set_wr(0, 5, {8{8'h11}}, 8'hFF); go(); clear_in();
        set_wr(0, 5, {8{8'hAA}}, 8'hFF); set_rd(0, 0, 5); go(); clear_in(); go(); go();
        set_wr(0, 5, {8{8'h22}}, 8'hF0); set_rd(1, 0, 5); go(); clear_in(); go(); go();
        set_rd(2, 0, 5); go(); clear_in(); go(); go();

        // reset with a read in flight
        set_rd(0, 2, 1); go(); clear_in();
        do_reset();
        go(); go(); go();
        for (int c = 0; c < NC; c++) set_rd(c, 2, c + 1);
        go(); clear_in(); go(); go();

        // random back-to-back traffic over initialised addresses
        repeat (30) begin
            clear_in();
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(3, 0) != 0) begin
                    rb = int'($urandom_range(3, 0));
                    set_rd(c, rb, (rb == 2) ? 1 : 'h20);
                end
            end
            if ($urandom_range(3, 0) == 0) begin
                rb = int'($urandom_range(3, 0));
                set_wr(rb, (rb == 2) ? 1 : 'h20, {$urandom, $urandom}, 8'hFF);
            end
            go();
        end
        clear_in(); go(); go(); go();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
